// File: rtl/jpeg_cone_aoi322_pipe_if.sv
// rtl/jpeg_cone_aoi322_pipe_if.sv - valid/ready beat bus for the AOI322 cone pipeline
interface jpeg_cone_aoi322_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] a3;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, a1, a2, a3, b1, b2, c1, c2, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a1, a2, a3, b1, b2, c1, c2, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/jpeg_cone_aoi322_pipe.sv
// rtl/jpeg_cone_aoi322_pipe.sv - two-stage valid/ready AOI322 cone with zero-result beat counter
module jpeg_cone_aoi322_pipe #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jpeg_cone_aoi322_pipe_if.slave bus,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       zero_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic             adv1, adv2, accept, deliver;

    always_comb begin
        adv2    = !s2_valid_q || bus.out_ready;
        adv1    = !s1_valid_q || adv2;
        accept  = bus.in_valid && adv1;
        deliver = s2_valid_q && bus.out_ready;

        // Operand terms only load on an accepted beat, so idle X never reaches y.
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        q_d        = q_q;
        r_d        = r_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            p_d        = bus.a1 & bus.a2 & bus.a3;
            q_d        = bus.b1 & ~bus.b2;
            r_d        = (MODE != 0) ? (bus.c1 & ~bus.c2) : '0;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d = ~(p_q | q_q | r_q);
            end
        end

        zero_cnt_d = zero_cnt_q;
        if (cnt_clr) begin
            zero_cnt_d = '0;
        end else if (deliver && (y_q == '0) && (zero_cnt_q != CNT_MAX)) begin
            zero_cnt_d = zero_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            p_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            y_q        <= '0;
            zero_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            p_q        <= p_d;
            q_q        <= q_d;
            r_q        <= r_d;
            y_q        <= y_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = y_q;
    assign zero_cnt      = zero_cnt_q;
endmodule

// File: tb/tb_jpeg_cone_aoi322_pipe.sv
// tb/tb_jpeg_cone_aoi322_pipe.sv - directed table-driven bench for the AOI322 cone pipeline
module tb_jpeg_cone_aoi322_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, out_ready, cnt_clr;
    logic [W-1:0] a1, a2, a3, b1, b2, c1, c2;
    logic [15:0]  zc0;
    logic [1:0]   zc1;

    jpeg_cone_aoi322_pipe_if #(.WIDTH(W)) bus0 ();
    jpeg_cone_aoi322_pipe_if #(.WIDTH(W)) bus1 ();

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
    assign bus0.a1 = a1; assign bus1.a1 = a1;
    assign bus0.a2 = a2; assign bus1.a2 = a2;
    assign bus0.a3 = a3; assign bus1.a3 = a3;
    assign bus0.b1 = b1; assign bus1.b1 = b1;
    assign bus0.b2 = b2; assign bus1.b2 = b2;
    assign bus0.c1 = c1; assign bus1.c1 = c1;
    assign bus0.c2 = c2; assign bus1.c2 = c2;

    jpeg_cone_aoi322_pipe #(.WIDTH(W), .MODE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .cnt_clr(cnt_clr), .zero_cnt(zc0)
    );
    jpeg_cone_aoi322_pipe #(.WIDTH(W), .MODE(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .cnt_clr(cnt_clr), .zero_cnt(zc1)
    );

    typedef struct {
        logic [7:0] a1, a2, a3, b1, b2, c1, c2;
        logic [7:0] y0, y1;
    } vec_t;
    vec_t vt[9];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          m_cnt0, m_cnt1, n_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_y(input logic [7:0] x1, x2, x3, y1_, y2_, z1, z2, input bit mode);
        return ~((x1 & x2 & x3) | (y1_ & ~y2_) | (mode ? (z1 & ~z2) : 8'h00));
    endfunction

    task automatic monitor();
        logic        f0, f1;
        logic [15:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            chk("zero_cnt0", 32'(zc0), 32'(m_cnt0));
            chk("zero_cnt1", 32'(zc1), 32'(m_cnt1));
            f0 = bus0.out_valid && out_ready;
            f1 = bus1.out_valid && out_ready;
            e  = 16'hxxxx;
            if (f0 || f1) begin
                chk("fire_pair", {30'd0, f0, f1}, 32'd3);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_y0", 32'(bus0.y), 32'(e[15:8]));
                    chk("stream_y1", 32'(bus1.y), 32'(e[7:0]));
                    n_out++;
                end
            end
            if (cnt_clr) begin
                m_cnt0 = 0;
                m_cnt1 = 0;
            end else if (f0 && e[15:8] == 8'h00 && m_cnt0 < 65535) begin
                m_cnt0++;
            end
            if (!cnt_clr && f1 && e[7:0] == 8'h00 && m_cnt1 < 3) m_cnt1++;
            if (in_valid && bus0.in_ready)
                exp_q.push_back({ref_y(a1, a2, a3, b1, b2, c1, c2, 1'b0),
                                 ref_y(a1, a2, a3, b1, b2, c1, c2, 1'b1)});
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        a1 = v.a1; a2 = v.a2; a3 = v.a3; b1 = v.b1; b2 = v.b2; c1 = v.c1; c2 = v.c2;
    endtask

    initial begin
        int acc;
        int base;
        logic ir;
        vec_t v;

        vt[0] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[1] = '{8'hF0, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2] = '{8'hF0, 8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h0F};
        vt[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        vt[4] = '{8'hAA, 8'hFF, 8'h0F, 8'h50, 8'h10, 8'h00, 8'h00, 8'hB5, 8'hB5};
        vt[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vt[6] = '{8'h3C, 8'h3C, 8'hFF, 8'hC3, 8'hFF, 8'h00, 8'h00, 8'hC3, 8'hC3};
        vt[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'hFF, 8'h55};
        vt[8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hF0, 8'h30, 8'hFE, 8'h3E};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        drive(vt[3]);
        n_out = 0;
        repeat (2) cycle();
        chk("rst_out_valid0", 32'(bus0.out_valid), 32'd0);
        chk("rst_out_valid1", 32'(bus1.out_valid), 32'd0);
        chk("rst_y0", 32'(bus0.y), 32'd0);
        chk("rst_zero_cnt0", 32'(zc0), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);

        // Single beat latency, with X on idle data after the accept.
        out_ready = 1'b1;
        drive(vt[0]);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        a1 = 'x; a2 = 'x; a3 = 'x; b1 = 'x; b2 = 'x; c1 = 'x; c2 = 'x;
        chk("lat_valid_n1", 32'(bus0.out_valid), 32'd0);
        cycle();
        chk("lat_valid_n2", 32'(bus0.out_valid), 32'd1);
        chk("lat_y", 32'(bus0.y), 32'h00);
        cycle();
        chk("lat_zero_cnt", 32'(zc0), 32'd1);
        drive(vt[3]);

        for (int i = 0; i < 9; i++) begin
            drive(vt[i]);
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            cycle();
            chk($sformatf("vec%0d_valid", i), 32'(bus0.out_valid), 32'd1);
            chk($sformatf("vec%0d_y0", i), 32'(bus0.y), 32'(vt[i].y0));
            chk($sformatf("vec%0d_y1", i), 32'(bus1.y), 32'(vt[i].y1));
        end
        cycle();

        // Back-pressure: two beats held, in_ready low, then released in order.
        out_ready = 1'b0;
        base = n_out;
        acc = 0;
        for (int t = 0; t < 20 && acc < 4; t++) begin
            v = '{8'h00, 8'h00, 8'h00, 8'(acc + 1), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
            drive(v);
            in_valid = 1'b1;
            if (t == 6) out_ready = 1'b1;
            #1;
            ir = bus0.in_ready;
            if (t >= 2 && t <= 5) begin
                chk("bp_in_ready_low", 32'(ir), 32'd0);
                chk("bp_hold_valid", 32'(bus0.out_valid), 32'd1);
                chk("bp_hold_y", 32'(bus0.y), 32'hFE);
            end
            if (ir) acc++;
            cycle();
        end
        in_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 32'd4);
        repeat (4) cycle();
        chk("bp_delivered", 32'(n_out - base), 32'd4);

        // Full throughput: 100 beats, one output per cycle after a 2-cycle fill.
        base = n_out;
        for (int j = 0; j < 106; j++) begin
            if (j < 100) begin
                a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
                b1 = 8'($urandom); b2 = 8'($urandom); c1 = 8'($urandom); c2 = 8'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (j < 100) chk("tp_in_ready", 32'(bus0.in_ready), 32'd1);
            chk($sformatf("tp_valid_%0d", j), 32'(bus0.out_valid), 32'((j >= 2 && j <= 101) ? 1 : 0));
            cycle();
        end
        chk("tp_delivered", 32'(n_out - base), 32'd100);

        // Saturation of the 2-bit counter and clear priority.
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        drive(vt[0]);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        chk("sat_zero_cnt1", 32'(zc1), 32'd3);
        chk("sat_zero_cnt0", 32'(zc0), 32'd5);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("clr_pre_valid", 32'(bus0.out_valid), 32'd1);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("clr_zero_cnt0", 32'(zc0), 32'd0);
        chk("clr_zero_cnt1", 32'(zc1), 32'd0);

        // Async reset with two beats in flight.
        v = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive(v);
        in_valid = 1'b1;
        cycle();
        drive(vt[0]);
        cycle();
        in_valid = 1'b0;
        chk("flight_valid", 32'(bus0.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid0", 32'(bus0.out_valid), 32'd0);
        chk("async_out_valid1", 32'(bus1.out_valid), 32'd0);
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("post_rst_valid", 32'(bus0.out_valid), 32'd0);
        end
        chk("post_rst_zero_cnt0", 32'(zc0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
